data_mem_responder: RTL and testbench

- Responder end of the pipeline's memory-stage load/store interface: accepts one request at a time from the MEM stage initiator and returns load data after a fixed, programmable latency.
- Drives a stall back to the hazard logic while a request is outstanding.
- Replaces the single-cycle data memory with a multi-cycle model, so the pipeline is exercised against realistic memory timing.

---
 rtl/data_mem_responder_pkg.sv | 35 +++
 rtl/data_mem_responder_mem_lane_align.sv | 52 +++++
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states,
// latency bounds and the byte-enable helper used by the lane aligner.
package data_mem_responder_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    function automatic logic latency_ok(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

    // Little-endian lane mask; halves sit on lanes {addr[1],0} and {addr[1],1}.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: be = 4'b0001 << addr_lo;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational lane steering: merges store data into the old word and
// extracts/extends load data from it.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] merged_word_o,
    output logic [31:0] load_data_o
);

    logic [3:0]  be_s;
    logic [31:0] wrep_s;
    logic [15:0] half_s;
    logic [7:0]  byte_s;

    assign be_s   = byte_enable(size_i, addr_lo_i);
    assign half_s = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    assign byte_s = old_word_i[{addr_lo_i, 3'b000} +: 8];

    // Store path: replicate right-justified data across lanes, then mask in.
    always_comb begin
        merged_word_o = old_word_i;
        case (size_i)
            SZ_WORD: wrep_s = wdata_i;
            SZ_HALF: wrep_s = {2{wdata_i[15:0]}};
            SZ_BYTE: wrep_s = {4{wdata_i[7:0]}};
            default: wrep_s = 32'd0;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
                merged_word_o[8*i +: 8] = wrep_s[8*i +: 8];
            end else begin
                merged_word_o[8*i +: 8] = old_word_i[8*i +: 8];
            end
        end
    end

    // Load path: pick the addressed lane(s) and extend.
    always_comb begin
        case (size_i)
            SZ_WORD: load_data_o = old_word_i;
            SZ_HALF: load_data_o = {{16{signed_i & half_s[15]}}, half_s};
            SZ_BYTE: load_data_o = {{24{signed_i & byte_s[7]}}, byte_s};
            default: load_data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the MEM stage: one outstanding
// request, fixed programmable latency, stall back to the hazard logic.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemStall
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAT_LOAD   = 4'(LATENCY - 1);

    if (!latency_ok(LATENCY)) begin : g_latency_check
        $error("data_mem_responder: LATENCY must be within 1..15");
    end

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic          signed_q, write_q;
    logic          resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          capture_s, access_s, err_resp_s, req_err_s, mem_we_s;
    logic [AW+1:0] acc_addr_s;
    logic [31:0]   acc_wdata_s;
    logic [1:0]    acc_size_s;
    logic          acc_signed_s, acc_write_s;
    logic [31:0]   old_word_s, merged_s, load_data_s;
    logic [31:0]   mem_q [DEPTH_WORDS];

    assign req_err_s = (req_size == SZ_RSVD)
                     | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                     | ((req_size == SZ_HALF) & req_addr[0])
                     | (req_addr >= BYTE_LIMIT);

    // With LATENCY=1 the access happens on the acceptance edge, so IDLE uses live inputs.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_addr_s   = req_addr[AW+1:0];
            acc_wdata_s  = req_wdata;
            acc_size_s   = req_size;
            acc_signed_s = req_signed;
            acc_write_s  = req_write;
        end else begin
            acc_addr_s   = addr_q;
            acc_wdata_s  = wdata_q;
            acc_size_s   = size_q;
            acc_signed_s = signed_q;
            acc_write_s  = write_q;
        end
    end

    assign old_word_s = mem_q[acc_addr_s[AW+1:2]];

    mem_lane_align u_lane_align (
        .old_word_i    (old_word_s),
        .wdata_i       (acc_wdata_s),
        .addr_lo_i     (acc_addr_s[1:0]),
        .size_i        (acc_size_s),
        .signed_i      (acc_signed_s),
        .merged_word_o (merged_s),
        .load_data_o   (load_data_s)
    );

    // Next-state, counter and response staging.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture_s  = 1'b0;
        access_s   = 1'b0;
        err_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    capture_s = 1'b1;
                    if (req_err_s) begin
                        err_resp_s = 1'b1;
                        state_d    = ST_RESP;
                    end else if (LATENCY == 1) begin
                        access_s = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        cnt_d   = LAT_LOAD;
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    access_s = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        resp_valid_d = access_s | err_resp_s;
        resp_err_d   = err_resp_s;
        resp_rdata_d = (access_s & ~acc_write_s) ? load_data_s : 32'd0;
    end

    // FSM, counter, captured request and registered response.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            if (capture_s) begin
                addr_q   <= req_addr[AW+1:0];
                wdata_q  <= req_wdata;
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
            end
        end
    end

    assign mem_we_s = access_s & acc_write_s & Reset;

    // Backing array deliberately survives reset.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            mem_q[acc_addr_s[AW+1:2]] <= merged_s;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign MemStall   = Reset & (((state_q == ST_IDLE) & req_valid) | (state_q == ST_BUSY));
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor
// pops and compares them against the LATENCY=2 instance; a LATENCY=1 instance is checked directly.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, MemStall;
    logic [31:0] resp_rdata;

    logic        v1, w1, sg1;
    logic [1:0]  sz1;
    logic [31:0] a1, wd1;
    logic        rdy1, rv1, er1, ms1;
    logic [31:0] rd1;

    always #5 Clk = ~Clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .MemStall(MemStall)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .req_valid(v1), .req_write(w1),
        .req_size(sz1), .req_signed(sg1), .req_addr(a1),
        .req_wdata(wd1), .req_ready(rdy1), .resp_valid(rv1),
        .resp_rdata(rd1), .resp_err(er1), .MemStall(ms1)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          stall;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   last_resp_cyc = 0;
    int   last_acc_cyc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: stall accounting and response comparison against the scoreboard.
    always @(negedge Clk) begin
        if (!Reset) begin
            stall_cnt = 0;
        end else begin
            if (MemStall) stall_cnt++;
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk({mon_e.name, "_rdata"}, resp_rdata, mon_e.rdata);
                    chk({mon_e.name, "_err"}, {31'd0, resp_err}, {31'd0, mon_e.err});
                    chk({mon_e.name, "_latency"}, cyc, mon_e.due);
                    chk({mon_e.name, "_stall_cycles"}, stall_cnt, mon_e.stall);
                    chk({mon_e.name, "_stall_in_resp"}, {31'd0, MemStall}, 32'd0);
                end
                last_resp_cyc = cyc;
                stall_cnt = 0;
            end
        end
    end

    // Present a request (called at posedge+1) and push its expected response once accepted.
    task automatic send(input string name, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t x;
        bit   ok = 1'b0;
        req_write = w; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            chk({name, "_stall_on_req"}, {31'd0, MemStall}, 32'd1);
            x.name = name; x.rdata = exp_rd; x.err = exp_err;
            x.due = cyc + (exp_err ? 1 : LAT);
            x.stall = exp_err ? 1 : LAT;
            sb_q.push_back(x);
            last_acc_cyc = cyc;
        end else begin
            chk({name, "_accept_timeout"}, 32'd0, 32'd1);
        end
        @(posedge Clk); #1;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            if (sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            chk({name, "_resp_timeout"}, 32'd0, 32'd1);
            sb_q.delete();
        end
        #1;
    endtask

    task automatic xact(input string name, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        send(name, w, sz, sg, addr, wd, exp_rd, exp_err);
        drain(name);
    endtask

    initial begin
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        v1 = 1'b0; w1 = 1'b0; sz1 = 2'b00; sg1 = 1'b0; a1 = 32'd0; wd1 = 32'd0;
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_memstall", {31'd0, MemStall}, 32'd0);
        req_valid = 1'b0;
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1;

        xact("sw_10",      1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        xact("lw_10",      1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        xact("lbs_11",     1'b0, 2'b10, 1'b1, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0);
        xact("lbu_13",     1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        32'h000000DE, 1'b0);
        xact("lhs_12",     1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
        xact("sb_12",      1'b1, 2'b10, 1'b0, 32'h12, 32'hAAAAAA55, 32'h0,        1'b0);
        xact("lw_10_sb",   1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hDE55BEEF, 1'b0);
        xact("lhu_12",     1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h0000DE55, 1'b0);
        xact("lbs_12",     1'b0, 2'b10, 1'b1, 32'h12, 32'h0,        32'h00000055, 1'b0);
        xact("sh_10",      1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF1234, 32'h0,        1'b0);
        xact("lw_10_sh",   1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hDE551234, 1'b0);
        xact("sw_00",      1'b1, 2'b00, 1'b0, 32'h00, 32'h01020304, 32'h0,        1'b0);
        xact("sw_ffc",     1'b1, 2'b00, 1'b0, 32'hFFC, 32'h0BADCAFE, 32'h0,       1'b0);
        xact("lw_ffc",     1'b0, 2'b00, 1'b0, 32'hFFC, 32'h0,       32'h0BADCAFE, 1'b0);

        xact("err_lw_02",  1'b0, 2'b00, 1'b0, 32'h02,   32'h0,        32'h0, 1'b1);
        xact("err_sh_01",  1'b1, 2'b01, 1'b0, 32'h01,   32'hFFFFFFFF, 32'h0, 1'b1);
        xact("err_lw_1000",1'b0, 2'b00, 1'b0, 32'h1000, 32'h0,        32'h0, 1'b1);
        xact("err_sw_1000",1'b1, 2'b00, 1'b0, 32'h1000, 32'hBAD0BAD0, 32'h0, 1'b1);
        xact("err_sz11",   1'b1, 2'b11, 1'b0, 32'h10,   32'h00000000, 32'h0, 1'b1);
        xact("lw_00_post", 1'b0, 2'b00, 1'b0, 32'h00, 32'h0, 32'h01020304, 1'b0);
        xact("lw_10_post", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hDE551234, 1'b0);

        // Reset pulsed while a store is in BUSY must abort it.
        xact("sw_20",      1'b1, 2'b00, 1'b0, 32'h20, 32'h11111111, 32'h0, 1'b0);
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(negedge Clk);
        chk("rst_abort_accept", {31'd0, req_ready}, 32'd1);
        @(posedge Clk); #2;
        Reset = 1'b0;
        #1;
        chk("rst_abort_stall", {31'd0, MemStall}, 32'd0);
        chk("rst_abort_resp", {31'd0, resp_valid}, 32'd0);
        @(posedge Clk); @(negedge Clk);
        chk("rst_abort_resp2", {31'd0, resp_valid}, 32'd0);
        chk("rst_abort_stall2", {31'd0, MemStall}, 32'd0);
        req_valid = 1'b0;
        Reset = 1'b1;
        @(posedge Clk); #1;
        xact("lw_20_rst",  1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

        // req_valid held through RESP; second request changes fields during BUSY.
        send("b2b_a", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hDE551234, 1'b0);
        send("b2b_b", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
        chk("b2b_accept_gap", last_acc_cyc, last_resp_cyc + 1);
        drain("b2b");

        // LATENCY=1 instance: response the cycle after each acceptance.
        w1 = 1'b1; sz1 = 2'b00; sg1 = 1'b0; a1 = 32'h40; wd1 = 32'hA5A5A5A5; v1 = 1'b1;
        @(negedge Clk);
        chk("l1_sw_ready", {31'd0, rdy1}, 32'd1);
        chk("l1_sw_stall", {31'd0, ms1}, 32'd1);
        chk("l1_sw_no_early_resp", {31'd0, rv1}, 32'd0);
        @(posedge Clk); #1;
        v1 = 1'b0;
        @(negedge Clk);
        chk("l1_sw_resp", {31'd0, rv1}, 32'd1);
        chk("l1_sw_rdata", rd1, 32'd0);
        chk("l1_sw_stall_resp", {31'd0, ms1}, 32'd0);
        @(posedge Clk); #1;
        w1 = 1'b0; sz1 = 2'b10; sg1 = 1'b1; a1 = 32'h41; v1 = 1'b1;
        @(negedge Clk);
        chk("l1_lb_ready", {31'd0, rdy1}, 32'd1);
        @(posedge Clk); #1;
        v1 = 1'b0;
        @(negedge Clk);
        chk("l1_lb_resp", {31'd0, rv1}, 32'd1);
        chk("l1_lb_rdata", rd1, 32'hFFFFFFA5);
        chk("l1_lb_err", {31'd0, er1}, 32'd0);
        @(posedge Clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
